// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem transaction at a time, buffers words in a prefetch FIFO.
// Latency: imem ack at edge N -> if_valid after edge N; zero-wait memory sustains one word per cycle.
// Backpressure: stall_en holds the FIFO head; no new request issues while the FIFO cannot take its word.

// Generic FIFO with synchronous flush; head is the registered entry at the read pointer.
module if_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage needs no reset: count guards every read.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        id_valid,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic        stall_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic        halted
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   RESET_PC_W = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_ent_t;

    logic [31:0]   pc;
    logic          busy;
    logic          drop;
    logic [CW-1:0] fifo_cnt;
    fetch_ent_t    push_ent;
    fetch_ent_t    head_ent;

    logic          ack_fire;
    logic          ctl_ok;
    logic          redirect;
    logic          illegal;
    logic          flush;
    logic          fifo_empty;
    logic          accept;
    logic          push;
    logic          hold;
    logic          issue;
    logic          halted_nxt;
    logic          drop_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   target;
    logic [31:0]   pc_nxt;

    // Control events decoded from ID, plus fetch-side handshake terms.
    always_comb begin
        ack_fire   = busy & imem_ack;
        ctl_ok     = id_valid & ~stall_en;
        redirect   = ctl_ok & ((pcsource == 2'b01) | (pcsource == 2'b10));
        illegal    = ctl_ok & (pcsource == 2'b11);
        flush      = redirect | illegal;
        fifo_empty = (fifo_cnt == '0);
        // ID latches a bubble whenever it is itself redirecting or trapping.
        if_valid   = ~fifo_empty & ~flush & ~halted;
        accept     = if_valid & ~stall_en;
        // Stale, flushed or post-halt words never enter the FIFO.
        push       = ack_fire & ~drop & ~flush & ~halted;
        push_ent   = '{inst: imem_rdata, pc4: imem_addr + 32'd4};
    end

    // Next-state of PC, drop flag and occupancy used to decide the next request.
    always_comb begin
        target     = (pcsource == 2'b01) ? bpc : jpc;
        target     = {target[31:2], 2'b00};
        pc_nxt     = pc;
        if (redirect) begin
            pc_nxt = target;
        end else if (ack_fire && !drop) begin
            pc_nxt = pc + 32'd4;
        end
        halted_nxt = halted | illegal;
        hold       = busy & ~imem_ack;
        // A redirect or trap while a transaction is in flight lets it finish but marks its data stale.
        drop_nxt   = drop;
        if (ack_fire) begin
            drop_nxt = 1'b0;
        end else if (hold && flush) begin
            drop_nxt = 1'b1;
        end
        cnt_nxt    = flush ? '0 : (fifo_cnt + CW'(push) - CW'(accept));
        // The request decision is made for the following cycle, so any clocked edge out of reset already
        // satisfies the "running" condition and the first request appears right after that edge.
        issue      = ~halted_nxt & (cnt_nxt < DEPTH_C);
    end

    // PC, request and sticky state registers; imem_addr is frozen while a transaction is outstanding.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc        <= RESET_PC_W;
            busy      <= 1'b0;
            drop      <= 1'b0;
            halted    <= 1'b0;
            imem_addr <= RESET_PC_W;
        end else begin
            pc     <= pc_nxt;
            busy   <= hold | issue;
            drop   <= drop_nxt;
            halted <= halted_nxt;
            if (!hold) begin
                imem_addr <= pc_nxt;
            end
        end
    end

    if_fifo #(
        .W     ($bits(fetch_ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push     (push),
        .push_dat (push_ent),
        .pop      (accept),
        .flush    (flush),
        .head_dat (head_ent),
        .count    (fifo_cnt)
    );

    // Head fields read as zero when nothing is buffered.
    always_comb begin
        imem_req = busy;
        if_inst  = fifo_empty ? 32'h0 : head_ent.inst;
        if_pc4   = fifo_empty ? 32'h0 : head_ent.pc4;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage pipeline, consuming the `pcsource`, `stall_en` and branch/jump targets produced by the ID-stage control unit. It owns the PC and issues word fetches to instruction memory over a req/ack handshake that tolerates variable latency. Fetched words are held in a small prefetch FIFO that feeds the IF/ID latch. Wrong-path words are flushed on taken branches and jumps, and the unit halts on an illegal-instruction indication.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `DEPTH`, default 2: prefetch FIFO entries. Power of two, at least 2.

- `clock`, in, 1: single clock, rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `id_valid`, in, 1: ID holds a real instruction, so `pcsource` is meaningful.
- `pcsource`, in, 2: 00 sequential; 01 branch taken (`bpc`); 10 jump (`jpc`); 11 illegal.
- `bpc`, in, 32: branch target.
- `jpc`, in, 32: jump target.
- `stall_en`, in, 1: ID holds its instruction; nothing is popped.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: word address; bits [1:0] are always 0.
- `imem_ack`, in, 1: transfer completes at the edge where `imem_req & imem_ack`.
- `imem_rdata`, in, 32: instruction word, valid with `imem_ack`.
- `if_valid`, out, 1: `if_inst`/`if_pc4` are valid for the IF/ID latch.
- `if_inst`, out, 32: instruction at the FIFO head.
- `if_pc4`, out, 32: fetch address + 4 of the head instruction.
- `halted`, out, 1: sticky; set by an illegal instruction.

## Operation
- Derived events:
  - `accept = if_valid & ~stall_en`: FIFO pop.
  - `redirect = id_valid & ~stall_en & (pcsource==01 | pcsource==10)`.
  - `illegal = id_valid & ~stall_en & pcsource==11`.
- State:
  - `pc` (32 bits).
  - FIFO of {inst, pc4} with count 0..DEPTH.
  - `busy`: request outstanding.
  - `drop`: outstanding response is stale.
  - `halted`.
  - `run`: set 1 at the first edge with `resetn` high.
- Issue:
  - A new request starts when `run & ~halted & ~busy & count<DEPTH`.
  - `imem_req` is high for the whole transaction. `imem_addr = pc` stays stable until ack.
  - Only one transaction is outstanding at a time.
  - Ack is permitted in the first cycle of `imem_req`. Back-to-back transactions keep `imem_req` high.
- Completion edge, no redirect:
  - `pc <= pc + 4`, mod 2^32 (0xFFFF_FFFC wraps to 0).
  - Push {`imem_rdata`, old pc + 4} unless `drop`.
  - Clear `drop`.
- Redirect edge:
  - Flush the FIFO (count to 0).
  - `pc <= bpc` or `jpc`, with bits [1:0] forced to 0.
  - If a transaction is outstanding and not acking this cycle, set `drop`. The transaction still completes at the old address and its data is discarded; the next request uses the new pc.
  - If ack occurs in the same cycle, the word is discarded and `drop` stays 0.
- Illegal edge:
  - Flush the FIFO and set `halted`.
  - Any outstanding transaction completes with data discarded.
  - No further requests are issued. Only reset clears `halted`.
- Output gating:
  - `if_valid = count!=0 & ~redirect & ~illegal & ~halted`, so ID latches a bubble in a redirect or illegal cycle.
  - `if_inst` and `if_pc4` are 0 when the FIFO is empty.
- Simultaneous events:
  - Push and pop on the same edge leave count unchanged.
  - Redirect and illegal are exclusive by encoding.
  - Flush overrides both push and pop.
- Overflow is impossible by construction: count never rises while a request is outstanding, except by that request's own push.
- Reset values (asynchronous):
  - `pc = RESET_PC`; count, `busy`, `drop`, `halted`, `run` = 0.
  - `imem_req = 0`, `imem_addr = RESET_PC`, `if_valid = 0`, `if_inst = 0`, `if_pc4 = 0`, `halted = 0`.
  - A mid-transaction reset abandons the transaction immediately. Instruction memory must tolerate `imem_req` dropping without ack.

## Timing
- First `imem_req` is high in the cycle after the first rising edge with `resetn` high.
- Fetch latency: an ack at edge N makes `if_valid` high after edge N. There is no combinational path from `imem_*` to `if_*`.
- Zero-wait memory (ack in the request cycle) with continuous `accept` sustains one instruction per cycle.
- Taken redirect at edge N:
  - Zero-wait memory: target request in cycle N+1; target instruction valid after edge N+1. This is a 1-bubble penalty beyond the gated cycle.
  - Outstanding slow transaction: the target request starts the cycle after the stale ack.
- `if_valid` depends combinationally on `id_valid`, `pcsource` and `stall_en`. All other outputs are registered.

## Test plan
- Reset release, zero-wait memory returning `addr ^ 32'hA5A5_0000`, `stall_en=0`: requests to 0, 4, 8, …; `if_valid` high from the 3rd cycle; each `if_pc4` = addr+4; one instruction per cycle.
- Hold `stall_en=1` for 5 cycles with DEPTH=2: FIFO fills to 2, then `imem_req` stays 0; after release the same two words drain in order and fetching resumes at the next address.
- Ack delayed 3 cycles on request to 0x10; redirect to `bpc=0x100` in its 2nd cycle: `imem_addr` stays 0x10 until ack, the 0x10 data never appears, next request is to 0x100, and the first valid `if_pc4 = 0x104`.
- Jump with `jpc=0x203` on the same cycle as an ack: ack data dropped, FIFO empty, next request to 0x200, `if_valid` low in the redirect cycle.
- `id_valid=1`, `pcsource=11`: `halted` set after the edge, FIFO flushed, no further `imem_req` after the in-flight ack; `resetn` pulse restores fetching at `RESET_PC`.
- `RESET_PC=32'hFFFF_FFF8`: fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0; `if_pc4` for 0xFFFF_FFFC is 0x0.
